sprite_move_sequencer: RTL and testbench

- Drives the request side of the sprite position-update interface.
- On each game tick it steps through the five sprites in a fixed order: Pacman, Blinky, Pinky, Inky, Clyde.
- For each sprite it presents the current position, a latched move direction and the sprite index to the position-update function, waits the update latency, then commits the returned position into its own register file.
- It is the sole owner of all sprite positions and feeds the renderer and game logic.

---
 rtl/sprite_move_sequencer_pkg.sv | 53 +++++
 rtl/sprite_move_sequencer_if.sv | 23 ++
 rtl/sprite_move_sequencer_pos_regfile.sv | 40 ++++
 rtl/sprite_move_sequencer.sv | 128 ++++++++++++
 tb/tb_sprite_move_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_move_sequencer_pkg.sv
// Shared sprite constants, direction encodings and the reset-position table.
// Also used by the position-update function, so both sides agree on indices and reset positions.
package sprite_move_sequencer_pkg;

  localparam int NUM_SPRITES = 5;
  localparam int X_W         = 11;
  localparam int Y_W         = 10;
  localparam int DIR_W       = 4;
  localparam int IDX_W       = 3;

  localparam logic [IDX_W-1:0] PACMAN = 3'd0;
  localparam logic [IDX_W-1:0] BLINKY = 3'd1;
  localparam logic [IDX_W-1:0] PINKY  = 3'd2;
  localparam logic [IDX_W-1:0] INKY   = 3'd3;
  localparam logic [IDX_W-1:0] CLYDE  = 3'd4;

  localparam logic [DIR_W-1:0] DIR_NONE  = 4'b0000;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 4'b0001;
  localparam logic [DIR_W-1:0] DIR_UP    = 4'b0010;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 4'b0100;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, DONE} state_e;

  function automatic logic [X_W-1:0] rst_x(input logic [IDX_W-1:0] k);
    case (k)
      PACMAN:  return 11'd967;
      BLINKY:  return 11'd663;
      PINKY:   return 11'd615;
      INKY:    return 11'd503;
      default: return 11'd615;
    endcase
  endfunction

  function automatic logic [Y_W-1:0] rst_y(input logic [IDX_W-1:0] k);
    case (k)
      PACMAN:  return 10'd66;
      BLINKY:  return 10'd434;
      PINKY:   return 10'd258;
      INKY:    return 10'd66;
      default: return 10'd370;
    endcase
  endfunction

  // Anything other than a single set bit means "stand still".
  function automatic logic [DIR_W-1:0] dir_sanitize(input logic [DIR_W-1:0] d);
    case (d)
      DIR_RIGHT, DIR_UP, DIR_DOWN, DIR_LEFT: return d;
      default:                               return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sprite_move_sequencer_if.sv
// Request/response bundle between the sequencer and the position-update function.
// Master presents the request; slave returns the new position UPD_LATENCY cycles later.
interface sprite_move_sequencer_if;
  import sprite_move_sequencer_pkg::*;

  logic [X_W-1:0]   upd_pos_x;
  logic [Y_W-1:0]   upd_pos_y;
  logic [DIR_W-1:0] upd_dir;
  logic [IDX_W-1:0] upd_sprite;
  logic             upd_rst;
  logic [X_W-1:0]   upd_new_x;
  logic [Y_W-1:0]   upd_new_y;

  modport master (
    output upd_pos_x, upd_pos_y, upd_dir, upd_sprite, upd_rst,
    input  upd_new_x, upd_new_y
  );

  modport slave (
    input  upd_pos_x, upd_pos_y, upd_dir, upd_sprite, upd_rst,
    output upd_new_x, upd_new_y
  );
endinterface

// File: rtl/sprite_move_sequencer_pos_regfile.sv
// sprite_pos_regfile: 5-entry x/y store, resets to the start table, one write port, flattened read-out.
// Write lands on the clock edge; reads are combinational. No backpressure.
module sprite_pos_regfile
  import sprite_move_sequencer_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [IDX_W-1:0]         waddr_i,
  input  logic [X_W-1:0]           wx_i,
  input  logic [Y_W-1:0]           wy_i,
  output logic [NUM_SPRITES*X_W-1:0] pos_x_o,
  output logic [NUM_SPRITES*Y_W-1:0] pos_y_o
);

  logic [X_W-1:0] x_q [NUM_SPRITES];
  logic [Y_W-1:0] y_q [NUM_SPRITES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        x_q[k] <= rst_x(IDX_W'(k));
        y_q[k] <= rst_y(IDX_W'(k));
      end
    end else begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        if (we_i && (waddr_i == IDX_W'(k))) begin
          x_q[k] <= wx_i;
          y_q[k] <= wy_i;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_out
    assign pos_x_o[X_W*k +: X_W] = x_q[k];
    assign pos_y_o[Y_W*k +: Y_W] = y_q[k];
  end

endmodule

// File: rtl/sprite_move_sequencer.sv
// Per tick, walks Pacman..Clyde through the position-update function and commits results; (UPD_LATENCY+1) cycles per sprite.
// Ticks arriving mid-pass are dropped. Optional SPRITE_COLLIDE_EN adds a registered Pacman/ghost overlap flag.
module sprite_move_sequencer
  import sprite_move_sequencer_pkg::*;
#(
  parameter int UPD_LATENCY = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       tick_i,
  input  logic                       restart_i,
  input  logic [NUM_SPRITES*DIR_W-1:0] dir_in_i,
  sprite_move_sequencer_if.master    upd,
  output logic [NUM_SPRITES*X_W-1:0] pos_x_o,
  output logic [NUM_SPRITES*Y_W-1:0] pos_y_o,
  output logic                       busy_o,
  output logic                       done_o
`ifdef SPRITE_COLLIDE_EN
  ,
  output logic                       collide_o
`endif
);

  localparam logic [1:0] CNT_LOAD = 2'(UPD_LATENCY - 1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic [NUM_SPRITES*DIR_W-1:0] dir_q, dir_d;
  logic                       restart_q, restart_d;
  logic                       we;
  logic                       in_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      idx_q     <= PACMAN;
      cnt_q     <= '0;
      dir_q     <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      restart_q <= restart_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    restart_d = restart_q;
    we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_i) begin
          dir_d     = dir_in_i;
          restart_d = restart_i;
          idx_d     = PACMAN;
          cnt_d     = CNT_LOAD;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) state_d = COMMIT;
        else               cnt_d   = cnt_q - 2'd1;
      end
      COMMIT: begin
        we = 1'b1;
        if (idx_q == CLYDE) begin
          // Park the index on slot 0 so idle request outputs show Pacman.
          idx_d   = PACMAN;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  sprite_pos_regfile u_regfile (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (we),
    .waddr_i (idx_q),
    .wx_i    (upd.upd_new_x),
    .wy_i    (upd.upd_new_y),
    .pos_x_o (pos_x_o),
    .pos_y_o (pos_y_o)
  );

  assign in_req         = (state_q == WAIT) || (state_q == COMMIT);
  assign upd.upd_pos_x  = pos_x_o[X_W*int'(idx_q) +: X_W];
  assign upd.upd_pos_y  = pos_y_o[Y_W*int'(idx_q) +: Y_W];
  assign upd.upd_sprite = idx_q;
  assign upd.upd_dir    = in_req ? dir_sanitize(dir_q[DIR_W*int'(idx_q) +: DIR_W]) : DIR_NONE;
  assign upd.upd_rst    = restart_q && (state_q != IDLE);
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);

`ifdef SPRITE_COLLIDE_EN
  logic collide_q;
  logic hit;

  always_comb begin
    hit = 1'b0;
    for (int k = 1; k < NUM_SPRITES; k++) begin
      if ((pos_x_o[X_W*k +: X_W] == pos_x_o[X_W-1:0]) &&
          (pos_y_o[Y_W*k +: Y_W] == pos_y_o[Y_W-1:0])) hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               collide_q <= 1'b0;
    else if (state_q == DONE)  collide_q <= hit;
  end

  assign collide_o = collide_q;
`endif

endmodule

// File: tb/tb_sprite_move_sequencer.sv
// Scoreboard bench: stimulus queues expected requests and pass results; a negedge monitor pops and compares.
module tb_sprite_move_sequencer;

  typedef struct {
    logic [2:0]  spr;
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  d;
    logic        r;
  } req_t;

  typedef struct {
    logic [54:0] px;
    logic [49:0] py;
    logic        col;
  } done_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        restart = 1'b0;
  logic [19:0] dir_in = '0;
  logic [54:0] pos_x;
  logic [49:0] pos_y;
  logic        busy;
  logic        done;
  logic        collide;
  logic        teleport = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int n_done = 0;
  int edge_cnt = 0;
  int last_tick_edge = 0;

  req_t  exp_req[$];
  done_t exp_done[$];
  logic [10:0] mx[5];
  logic [9:0]  my[5];

  sprite_move_sequencer_if intf ();

  sprite_move_sequencer #(.UPD_LATENCY(1)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .tick_i    (tick),
    .restart_i (restart),
    .dir_in_i  (dir_in),
    .upd       (intf),
    .pos_x_o   (pos_x),
    .pos_y_o   (pos_y),
    .busy_o    (busy),
    .done_o    (done)
`ifdef SPRITE_COLLIDE_EN
    ,
    .collide_o (collide)
`endif
  );

`ifndef SPRITE_COLLIDE_EN
  assign collide = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [10:0] rx(input int k);
    case (k)
      0: return 11'd967;
      1: return 11'd663;
      2: return 11'd615;
      3: return 11'd503;
      default: return 11'd615;
    endcase
  endfunction

  function automatic logic [9:0] ry(input int k);
    case (k)
      0: return 10'd66;
      1: return 10'd434;
      2: return 10'd258;
      3: return 10'd66;
      default: return 10'd370;
    endcase
  endfunction

  function automatic logic [3:0] san(input logic [3:0] d);
    return ($countones(d) == 1) ? d : 4'b0000;
  endfunction

  // Position-update function model: restart -> table, else step 16 in the requested direction.
  function automatic logic [20:0] upd_fn(input logic [10:0] x, input logic [9:0] y,
                                         input logic [3:0] d, input logic r,
                                         input int k, input logic tp);
    if (r) return {rx(k), ry(k)};
    if (tp && k == 0) return {11'd503, 10'd66};
    case (d)
      4'b0001: return {x + 11'd16, y};
      4'b1000: return {x - 11'd16, y};
      4'b0010: return {x, y - 10'd16};
      4'b0100: return {x, y + 10'd16};
      default: return {x, y};
    endcase
  endfunction

  always_comb begin
    {intf.upd_new_x, intf.upd_new_y} = upd_fn(intf.upd_pos_x, intf.upd_pos_y, intf.upd_dir,
                                              intf.upd_rst, int'(intf.upd_sprite), teleport);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [54:0] table_x();
    logic [54:0] v;
    for (int k = 0; k < 5; k++) v[11*k +: 11] = rx(k);
    return v;
  endfunction

  function automatic logic [49:0] table_y();
    logic [49:0] v;
    for (int k = 0; k < 5; k++) v[10*k +: 10] = ry(k);
    return v;
  endfunction

  // Monitor: a new request is presented when busy rises or the sprite index moves.
  logic       busy_prev = 1'b0;
  logic [2:0] spr_prev = '0;
  logic       col_pending = 1'b0;
  logic       col_exp = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (col_pending) begin
        check("collide", {63'd0, collide}, {63'd0, col_exp});
        col_pending = 1'b0;
      end
      if (busy && !done && (!busy_prev || intf.upd_sprite != spr_prev)) begin
        if (exp_req.size() == 0) begin
          check("unexpected_req", {61'd0, intf.upd_sprite}, 64'hFFFF);
        end else begin
          req_t e;
          e = exp_req.pop_front();
          check("req_sprite", {61'd0, intf.upd_sprite}, {61'd0, e.spr});
          check("req_x", {53'd0, intf.upd_pos_x}, {53'd0, e.x});
          check("req_y", {54'd0, intf.upd_pos_y}, {54'd0, e.y});
          check("req_dir", {60'd0, intf.upd_dir}, {60'd0, e.d});
          check("req_rst", {63'd0, intf.upd_rst}, {63'd0, e.r});
        end
      end
      if (done) begin
        n_done++;
        if (exp_done.size() == 0) begin
          check("unexpected_done", 64'(edge_cnt), 64'hFFFF);
        end else begin
          done_t e;
          e = exp_done.pop_front();
          check("done_pos_x", {9'd0, pos_x}, {9'd0, e.px});
          check("done_pos_y", {14'd0, pos_y}, {14'd0, e.py});
          check("done_timing", 64'(edge_cnt - last_tick_edge), 64'd10);
`ifdef SPRITE_COLLIDE_EN
          col_exp = e.col;
          col_pending = 1'b1;
`endif
        end
      end
    end
    busy_prev = busy;
    spr_prev  = intf.upd_sprite;
  end

  // mode 0: plain pass, 1: pass with timing/drop/dir-change probes, 2: reset mid-pass.
  task automatic run_pass(input logic [19:0] dirs, input logic rs, input logic tp, input int mode);
    logic [10:0] nx[5];
    logic [9:0]  ny[5];
    logic [20:0] r;
    logic [3:0]  d;
    done_t       dr;
    int          last;
    last = (mode == 2) ? 2 : 4;
    for (int k = 0; k < 5; k++) begin
      d = san(dirs[4*k +: 4]);
      if (k <= last) exp_req.push_back('{3'(k), mx[k], my[k], d, rs});
      r = upd_fn(mx[k], my[k], d, rs, k, tp);
      nx[k] = r[20:10];
      ny[k] = r[9:0];
    end
    if (mode != 2) begin
      dr.col = 1'b0;
      for (int k = 0; k < 5; k++) begin
        mx[k] = nx[k];
        my[k] = ny[k];
        dr.px[11*k +: 11] = nx[k];
        dr.py[10*k +: 10] = ny[k];
      end
      for (int k = 1; k < 5; k++) if (mx[k] == mx[0] && my[k] == my[0]) dr.col = 1'b1;
      exp_done.push_back(dr);
    end
    teleport = tp;
    dir_in   = dirs;
    restart  = rs;
    tick     = 1'b1;
    @(negedge clk);
    tick    = 1'b0;
    restart = 1'b0;
    last_tick_edge = edge_cnt;
    check("busy_start", {63'd0, busy}, 64'd1);
    if (mode == 1) dir_in = 20'h88888;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (mode == 1 && i == 1) check("pac_precommit_x", {53'd0, pos_x[10:0]}, 64'd967);
      if (mode == 1 && i == 2) begin
        check("pac_commit_x", {53'd0, pos_x[10:0]}, {53'd0, mx[0]});
        tick = 1'b1;
      end
      if (mode == 1 && i == 3) tick = 1'b0;
      if (mode == 2 && i == 4) begin
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_pos_x", {9'd0, pos_x}, {9'd0, table_x()});
        check("abort_pos_y", {14'd0, pos_y}, {14'd0, table_y()});
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
          mx[k] = rx(k);
          my[k] = ry(k);
        end
        break;
      end
    end
    check("busy_end", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 5; k++) begin
      mx[k] = rx(k);
      my[k] = ry(k);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pac_x", {53'd0, pos_x[10:0]}, 64'd967);
    check("rst_pac_y", {54'd0, pos_y[9:0]}, 64'd66);
    check("rst_clyde_x", {53'd0, pos_x[54:44]}, 64'd615);
    check("rst_clyde_y", {54'd0, pos_y[49:40]}, 64'd370);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_upd_rst", {63'd0, intf.upd_rst}, 64'd0);
    check("rst_upd_dir", {60'd0, intf.upd_dir}, 64'd0);
    check("rst_upd_sprite", {61'd0, intf.upd_sprite}, 64'd0);
    check("rst_upd_pos_x", {53'd0, intf.upd_pos_x}, 64'd967);
    check("rst_collide", {63'd0, collide}, 64'd0);

    // Pacman RIGHT, Blinky invalid 0011, Pinky DOWN, Inky UP, Clyde LEFT.
    run_pass(20'h82431, 1'b0, 1'b0, 1);
    run_pass(20'h11111, 1'b1, 1'b0, 0);

    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
    check("restart_alone_busy", {63'd0, busy}, 64'd0);

    run_pass(20'h11111, 1'b0, 1'b0, 2);
    run_pass(20'h00000, 1'b0, 1'b1, 0);
    run_pass(20'h00001, 1'b0, 1'b0, 0);

    repeat (4) @(negedge clk);
    check("req_queue_empty", 64'(exp_req.size()), 64'd0);
    check("done_queue_empty", 64'(exp_done.size()), 64'd0);
    check("done_pulse_count", 64'(n_done), 64'd4);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
